// File: rtl/vector_pkg.sv
// Shared types and default sizing for the vector subtract unit.
// Imported by the interface, the top and the bench.
package vector_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int LANES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/vector_sub_unit_if.sv
// Command/result bundle between a requester and vector_sub_unit.
// Lane i of each vector occupies bits [i*WIDTH +: WIDTH].
interface vector_sub_unit_if
    import vector_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANES = LANES_DEF
) ();

    logic                     start;
    logic                     chain;
    logic                     sat;
    logic [LANES*WIDTH-1:0]   vec_a;
    logic [LANES*WIDTH-1:0]   vec_b;
    logic                     busy;
    logic                     done;
    logic [LANES*WIDTH-1:0]   vec_d;
    logic [LANES-1:0]         borrow_flags;
    logic                     borrow_out;

    modport master (
        output start, chain, sat, vec_a, vec_b,
        input  busy, done, vec_d, borrow_flags, borrow_out
    );

    modport slave (
        input  start, chain, sat, vec_a, vec_b,
        output busy, done, vec_d, borrow_flags, borrow_out
    );

endinterface

// File: rtl/vector_sub_unit_full_subtractor.sv
// WIDTH-bit subtract with borrow in/out: d = a - b - bin mod 2^WIDTH.
// Shared by all lanes of vector_sub_unit.
module Full_Subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic [WIDTH-1:0] d_o,
    output logic             bout_o
);

    logic [WIDTH:0] diff;

    assign diff   = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, bin_i};
    assign d_o    = diff[WIDTH-1:0];
    assign bout_o = diff[WIDTH];

endmodule

// File: rtl/vector_sub_unit.sv
// Lane-serial vector subtractor: one shared subtractor walks the lanes,
// either independently (optionally saturating) or as one wide chained subtract.
module vector_sub_unit
    import vector_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    vector_sub_unit_if.slave io
);

    localparam int N  = LANES * WIDTH;
    localparam int CW = $clog2(LANES + 1);
    localparam logic [CW-1:0] LAST = CW'(LANES);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    a_q, b_q;
    logic            chain_q, sat_q, bin_q;
    logic [N-1:0]    acc_q;
    logic [LANES-1:0] flg_q;
    logic [N-1:0]    vec_d_q;
    logic [LANES-1:0] flags_q;
    logic            bout_q;

    logic             accept, step, publish;
    logic [WIDTH-1:0] fs_d, lane_d;
    logic             fs_bout;

    Full_Subtractor #(.WIDTH(WIDTH)) u_fs (
        .a_i    (a_q[WIDTH-1:0]),
        .b_i    (b_q[WIDTH-1:0]),
        .bin_i  (chain_q & bin_q),
        .d_o    (fs_d),
        .bout_o (fs_bout)
    );

    assign lane_d = (sat_q && !chain_q && fs_bout) ? '0 : fs_d;

    always_comb begin
        state_d = state_q;
        accept  = io.start && (state_q != RUN);
        step    = (state_q == RUN) && (cnt_q != LAST);
        publish = (state_q == RUN) && (cnt_q == LAST);
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (publish) state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            chain_q <= 1'b0;
            sat_q   <= 1'b0;
            bin_q   <= 1'b0;
            acc_q   <= '0;
            flg_q   <= '0;
            vec_d_q <= '0;
            flags_q <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= io.vec_a;
                b_q     <= io.vec_b;
                chain_q <= io.chain;
                sat_q   <= io.sat;
                cnt_q   <= '0;
                bin_q   <= 1'b0;
                acc_q   <= '0;
                flg_q   <= '0;
            end else if (step) begin
                // operands shift down so lane cnt_q is always at the bottom
                a_q   <= a_q >> WIDTH;
                b_q   <= b_q >> WIDTH;
                acc_q <= {lane_d, acc_q[N-1:WIDTH]};
                flg_q <= {fs_bout, flg_q[LANES-1:1]};
                bin_q <= fs_bout;
                cnt_q <= cnt_q + 1'b1;
            end
            if (publish) begin
                vec_d_q <= acc_q;
                flags_q <= flg_q;
                bout_q  <= chain_q ? flg_q[LANES-1] : |flg_q;
            end
        end
    end

    assign io.busy         = (state_q == RUN);
    assign io.done         = (state_q == DONE);
    assign io.vec_d        = vec_d_q;
    assign io.borrow_flags = flags_q;
    assign io.borrow_out   = bout_q;

endmodule

// File: tb/tb_vector_sub_unit.sv
// Scoreboard bench for vector_sub_unit at WIDTH=4, LANES=4.
module tb_vector_sub_unit;

    localparam int W = 4;
    localparam int L = 4;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  f;
        logic        bo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vector_sub_unit_if #(.WIDTH(W), .LANES(L)) io ();

    vector_sub_unit #(.WIDTH(W), .LANES(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;
    int n_done = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input logic s);
        exp_t e;
        int bw;
        e = '0;
        bw = 0;
        for (int i = 0; i < 4; i++) begin
            int x, y, r;
            x = int'(a[i*4 +: 4]);
            y = int'(b[i*4 +: 4]);
            r = x - y - (c ? bw : 0);
            bw = (r < 0) ? 1 : 0;
            if (r < 0) r += 16;
            if (s && !c && bw == 1) r = 0;
            e.d[i*4 +: 4] = r[3:0];
            e.f[i] = (bw == 1);
        end
        e.bo = c ? e.f[3] : |e.f;
        return e;
    endfunction

    always @(negedge clk) begin
        if (io.done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("vec_d", 32'(io.vec_d), 32'(e.d));
                check("borrow_flags", 32'(io.borrow_flags), 32'(e.f));
                check("borrow_out", 32'(io.borrow_out), 32'(e.bo));
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s);
        io.vec_a = a;
        io.vec_b = b;
        io.chain = c;
        io.sat   = s;
        io.start = 1'b1;
    endtask

    task automatic wait_done(input int k0, input int want, input string tag);
        int k;
        k = k0;
        while (!io.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k), 32'(want));
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic s, input exp_t e,
                      input bit sync, input string tag);
        if (sync) @(negedge clk);
        drive(a, b, c, s);
        sb.push_back(e);
        @(negedge clk);
        io.start = 1'b0;
        check({tag, "_busy"}, 32'(io.busy), 32'd1);
        wait_done(1, 6, {tag, "_latency"});
    endtask

    initial begin
        int d0;
        io.start = 1'b0;
        io.chain = 1'b0;
        io.sat   = 1'b0;
        io.vec_a = '0;
        io.vec_b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(io.busy), 32'd0);
        check("rst_done", 32'(io.done), 32'd0);
        check("rst_vec_d", 32'(io.vec_d), 32'd0);
        check("rst_flags", 32'(io.borrow_flags), 32'd0);
        rst_n = 1'b1;

        op(16'hF80A, 16'hFAF1, 1'b0, 1'b0, '{16'h0E19, 4'b0110, 1'b1}, 1, "elem");
        op(16'hF80A, 16'hFAF1, 1'b1, 1'b0, '{16'hFD19, 4'b1110, 1'b1}, 1, "chain");
        op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'h0000, 4'b0000, 1'b0}, 1, "chain_eq");
        op(16'hF80A, 16'hFAF1, 1'b0, 1'b1, '{16'h0009, 4'b0110, 1'b1}, 1, "sat");
        op(16'hF80A, 16'hFAF1, 1'b1, 1'b1, '{16'hFD19, 4'b1110, 1'b1}, 1, "chain_sat");
        op(16'h0000, 16'h0001, 1'b1, 1'b0, '{16'hFFFF, 4'b1111, 1'b1}, 1, "ripple");

        for (int i = 0; i < 6; i++) begin
            logic [15:0] a, b;
            logic c, s;
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom);
            s = 1'($urandom);
            op(a, b, c, s, model(a, b, c, s), 1, "rand");
        end

        // start held high through RUN while the operands change
        @(negedge clk);
        drive(16'h5A3C, 16'h1F2E, 1'b0, 1'b0);
        sb.push_back(model(16'h5A3C, 16'h1F2E, 1'b0, 1'b0));
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            drive(16'h0123, 16'hFEDC, 1'b1, 1'b1);
        end
        @(negedge clk);
        io.start = 1'b0;
        wait_done(5, 6, "held_latency");
        @(negedge clk);
        d0 = n_done;
        repeat (8) @(negedge clk);
        check("held_extra_done", 32'(n_done - d0), 32'd0);
        check("held_sb_empty", 32'(sb.size()), 32'd0);

        // back-to-back: second start issued in the DONE cycle
        op(16'h1357, 16'h2468, 1'b1, 1'b0, model(16'h1357, 16'h2468, 1'b1, 1'b0), 1, "b2b_a");
        op(16'hF80A, 16'hFAF1, 1'b0, 1'b0, '{16'h0E19, 4'b0110, 1'b1}, 0, "b2b_b");

        // reset while lane 2 is being computed
        @(negedge clk);
        drive(16'h8421, 16'h1248, 1'b0, 1'b0);
        @(negedge clk);
        io.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(io.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(io.busy), 32'd0);
        check("mid_rst_done", 32'(io.done), 32'd0);
        check("mid_rst_vec_d", 32'(io.vec_d), 32'd0);
        check("mid_rst_flags", 32'(io.borrow_flags), 32'd0);
        check("mid_rst_bout", 32'(io.borrow_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = n_done;
        repeat (10) @(negedge clk);
        check("rst_no_done", 32'(n_done - d0), 32'd0);

        op(16'hF80A, 16'hFAF1, 1'b0, 1'b0, '{16'h0E19, 4'b0110, 1'b1}, 1, "post_rst");

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vector_sub_unit.md
VECTOR_SUB_UNIT -- requirements
Module: vector_sub_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter WIDTH, default 8: element width in bits.
REQ-003 Parameter LANES, default 4: number of elements per vector.
REQ-004 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: request to begin an operation.
REQ-007 Port chain, input, 1: 1 selects one LANES*WIDTH-bit subtract with the borrow rippling lane to lane; 0 selects independent per-element subtract.
REQ-008 Port sat, input, 1: unsigned saturate-to-zero in element mode; ignored when chain=1.
REQ-009 Port vec_a, input, LANES*WIDTH: minuend; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-010 Port vec_b, input, LANES*WIDTH: subtrahend, same packing.
REQ-011 Port busy, output, 1: operation in progress.
REQ-012 Port done, output, 1: one-cycle pulse when results are valid.
REQ-013 Port vec_d, output, LANES*WIDTH: difference vector.
REQ-014 Port borrow_flags, output, LANES: borrow-out of each lane.
REQ-015 Port borrow_out, output, 1: summary borrow.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 The unit SHALL accept start only in IDLE or DONE, capturing vec_a, vec_b, chain and sat, clearing the lane index to 0 and entering RUN.
REQ-018 The unit SHALL ignore start while in RUN; captured operands remain unchanged.
REQ-019 In RUN the unit SHALL process one lane per cycle, lane 0 first: D_i = A_i - B_i - bin_i, modulo 2^WIDTH.
REQ-020 bin_0 SHALL be 0; for i>0, bin_i SHALL equal the borrow of lane i-1 when chain=1 and 0 otherwise.
REQ-021 When sat=1 and chain=0, a lane that borrows SHALL store D_i = 0; its borrow flag SHALL still be set.
REQ-022 After lane LANES-1 the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE unless start is accepted in that cycle.
REQ-023 Latency: start sampled at edge T SHALL give done=1 during the cycle after edge T+LANES+1.
REQ-024 vec_d, borrow_flags and borrow_out SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-025 borrow_out SHALL be the lane LANES-1 borrow when chain=1 and the OR of borrow_flags when chain=0.
REQ-026 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-027 start in DONE SHALL be accepted back-to-back; done pulses once per operation.

Reset
REQ-028 Asserting rst_n low SHALL immediately force IDLE and busy=0, done=0, vec_d=0, borrow_flags=0 and borrow_out=0, including mid-RUN.
REQ-029 An operation interrupted by reset SHALL be abandoned and never signal done.
REQ-030 The first start after rst_n deasserts SHALL behave as from power-up.

Structure
REQ-031 The state enum and the default WIDTH/LANES constants SHALL live in shared package vector_pkg.
REQ-032 The datapath SHALL instantiate one Full_Subtractor #(WIDTH) sub-module, time-multiplexed across lanes; no per-lane subtractor copies.

Verification (WIDTH=4, LANES=4)
REQ-033 Element mode: A=16'hF80A, B=16'hFAF1, chain=0, sat=0 -> vec_d=16'h0E19, borrow_flags=4'b0110, borrow_out=1, done 5 cycles after start.
REQ-034 Chain mode: the same A and B with chain=1 -> vec_d=16'hFD19, borrow_out=1; A=B=16'hFFFF -> vec_d=0, borrow_out=0.
REQ-035 Saturate: the same A and B with chain=0, sat=1 -> vec_d=16'h0009, borrow_flags=4'b0110.
REQ-036 Start held high through RUN with new operands -> exactly one done, result from the first operands; start in the DONE cycle -> second done 5 cycles later.
REQ-037 Reset pulse during RUN lane 2 -> all outputs 0 immediately, no done; the next start gives the correct result.
